fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Parametrised instruction-fetch sequencer that replaces the fixed single-cycle PC/IF path. It supports variable-latency instruction memory through a req/ack handshake, and issues instructions downstream through a valid/ready handshake. It applies relative or absolute branches, handles start and halt, and keeps wide retired-instruction and cycle counters. It sits between the instruction ROM and the control/decode stage of the processor top level.

Parameters:
PC_W, 8, program counter width in bits
INST_W, 10, instruction word width
CNT_W, 16, width of the retired-instruction and cycle counters
START_PC, 0, PC loaded on reset and on start

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
start  in  1  synchronous restart: reload START_PC, clear counters, begin fetching
halt_req  in  1  the instruction being consumed is a halt; sampled on consume
branch  in  2  branch mode for the consumed instruction: 00 none, 01 relative, 10 absolute, 11 reserved (treated as none)
branch_target  in  PC_W  signed offset (relative mode) or absolute address (absolute mode)
imem_req  out  1  instruction-memory request
imem_addr  out  PC_W  instruction-memory address
imem_ack  in  1  memory data valid this cycle
imem_data  in  INST_W  instruction word
inst_valid  out  1  instruction available downstream
inst_ready  in  1  downstream accepts the instruction
inst_out  out  INST_W  registered instruction
inst_pc  out  PC_W  PC of inst_out
PC  out  PC_W  current fetch PC
halted  out  1  sequencer is in HALTED
InstCounter  out  CNT_W  count of retired (consumed) instructions
CycleCounter  out  CNT_W  count of cycles spent outside IDLE/HALTED

Behaviour:
- Clock and reset: single clock CLK. RST_N is asynchronous and active-low.
- Reset values: state=IDLE, PC=START_PC, imem_req=0, inst_valid=0, inst_out=0, inst_pc=0, halted=0, both counters=0.
- State IDLE: outputs quiet. start=1 -> FETCH.
- State FETCH:
  - imem_req=1, imem_addr=PC.
  - imem_ack=1 -> capture inst_out=imem_data and inst_pc=PC; go to ISSUE next cycle.
  - Ack is allowed in the same cycle as req (minimum fetch latency is 1 cycle).
- State ISSUE:
  - inst_valid=1. inst_out and inst_pc are held stable until consumed.
  - Consume = inst_valid & inst_ready.
  - On consume, InstCounter increments (wraps modulo 2^CNT_W).
  - On consume with halt_req=1 -> HALTED; PC is unchanged.
  - Otherwise next PC:
    - branch 01: inst_pc + sign-extended branch_target, truncated to PC_W (wrap-around allowed).
    - branch 10: branch_target.
    - branch 00 or 11: inst_pc+1, wrapping from 2^PC_W-1 to 0.
  - After consume, go to FETCH.
- State HALTED: halted=1, no requests, counters frozen. Only start or reset leaves HALTED.
- Throughput: at most one instruction per 2 cycles. Next-PC is computed from the registered inst_pc.
- CycleCounter increments every cycle in FETCH or ISSUE; it wraps.
- Priority: RST_N > start > halt_req > branch.
- start in any state takes effect on the next edge:
  - PC=START_PC, counters cleared, inst_valid=0, state=FETCH.
  - Any in-flight fetch is abandoned. An imem_ack arriving in that cycle is ignored.
- Reset mid-operation: immediate return to reset values. A pending ack is dropped.
- imem_ack outside FETCH is ignored. branch and halt_req are ignored when no consume occurs.

Optional Feature:
STALL_COUNT_EN:
- Defined: adds output StallCounter, width CNT_W, reset 0, cleared on start. It increments each cycle in FETCH with imem_ack=0, and each cycle in ISSUE with inst_ready=0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, start, imem_ack tied 1, inst_ready tied 1, no branches, 5 instructions -> imem_addr 0,1,2,3,4; InstCounter=5; CycleCounter=10.
- Consume at inst_pc=3 with branch=01 and branch_target=-2 (PC_W=8) -> next imem_addr=1. Then branch=10 with target=0x40 -> next imem_addr=0x40.
- imem_ack delayed 3 cycles and inst_ready held low 2 cycles -> inst_out and inst_pc stable throughout, a single InstCounter increment, and StallCounter=5 when STALL_COUNT_EN is defined.
- Consume with halt_req=1 at inst_pc=7 -> halted=1, imem_req=0, counters frozen for 20 cycles. Then start -> PC=0, counters=0, fetching resumes.
- PC wrap: consume at inst_pc=0xFF with branch=00 -> next imem_addr=0x00.
- RST_N pulsed low during FETCH with an ack pending, and start asserted during ISSUE -> all outputs return to reset values immediately; after start, inst_valid=0 next cycle and refetch begins at START_PC.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction-memory and downstream-issue handshake bundle
//
// Purpose: groups the instruction-memory req/ack port and the downstream
// valid/ready issue port of fetch_sequencer.
// Signals:
//   imem_req/imem_addr   sequencer -> memory request and address
//   imem_ack/imem_data   memory -> sequencer data valid and instruction word
//   inst_valid/inst_out/inst_pc  sequencer -> decode, registered instruction and its PC
//   inst_ready           decode -> sequencer accept
// Modports: master (sequencer side), slave (memory/decode side).
interface fetch_sequencer_if #(
  parameter int PC_W   = 8,
  parameter int INST_W = 10
);
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_out;
  logic [PC_W-1:0]   inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    input  imem_ack, imem_data, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    output imem_ack, imem_data, inst_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - variable-latency instruction-fetch sequencer
//
// Purpose: fetches instructions over a req/ack memory port, holds each one
// registered on a valid/ready issue port, applies relative/absolute branches
// and halt on consume, and keeps retired-instruction and active-cycle counters.
// Optional build macro: STALL_COUNT_EN adds StallCounter.
// Ports:
//   CLK, RST_N        clock (rising edge), asynchronous active-low reset
//   start             synchronous restart from START_PC, clears counters
//   halt_req          consumed instruction is a halt
//   branch            00 none, 01 relative, 10 absolute, 11 none
//   branch_target     signed offset or absolute address
//   bus               fetch_sequencer_if.master (imem_* and inst_* handshakes)
//   PC                current fetch PC
//   halted            sequencer is halted
//   InstCounter       retired instruction count
//   CycleCounter      cycles spent in FETCH or ISSUE
//   StallCounter      (STALL_COUNT_EN only) FETCH-without-ack plus ISSUE-without-ready cycles
module fetch_sequencer #(
  parameter int              PC_W     = 8,
  parameter int              INST_W   = 10,
  parameter int              CNT_W    = 16,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start,
  input  logic                 halt_req,
  input  logic [1:0]           branch,
  input  logic [PC_W-1:0]      branch_target,
  fetch_sequencer_if.master    bus,
  output logic [PC_W-1:0]      PC,
  output logic                 halted,
  output logic [CNT_W-1:0]     InstCounter,
  output logic [CNT_W-1:0]     CycleCounter
`ifdef STALL_COUNT_EN
  ,
  output logic [CNT_W-1:0]     StallCounter
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] ISSUE  = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);

  logic [1:0]        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_out_q, inst_out_d;
  logic [PC_W-1:0]   inst_pc_q, inst_pc_d;
  logic [CNT_W-1:0]  inst_cnt_q, inst_cnt_d;
  logic [CNT_W-1:0]  cyc_cnt_q, cyc_cnt_d;
`ifdef STALL_COUNT_EN
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
`endif

  logic [PC_W-1:0]   next_pc;

  // Branch offset and PC share a width, so the adder's natural wrap is the
  // sign-extended, truncated relative target.
  always_comb begin
    next_pc = inst_pc_q + PC_ONE;
    case (branch)
      2'b01:   next_pc = inst_pc_q + branch_target;
      2'b10:   next_pc = branch_target;
      default: next_pc = inst_pc_q + PC_ONE;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_out_d = inst_out_q;
    inst_pc_d  = inst_pc_q;
    inst_cnt_d = inst_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
`ifdef STALL_COUNT_EN
    stall_cnt_d = stall_cnt_q;
`endif
    if (start) begin
      // Restart abandons any in-flight fetch; an ack this cycle is dropped.
      state_d    = FETCH;
      pc_d       = START_PC;
      inst_cnt_d = '0;
      cyc_cnt_d  = '0;
`ifdef STALL_COUNT_EN
      stall_cnt_d = '0;
`endif
    end else begin
      case (state_q)
        FETCH: begin
          cyc_cnt_d = cyc_cnt_q + CNT_ONE;
          if (bus.imem_ack) begin
            inst_out_d = bus.imem_data;
            inst_pc_d  = pc_q;
            state_d    = ISSUE;
          end
`ifdef STALL_COUNT_EN
          else begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
          end
`endif
        end
        ISSUE: begin
          cyc_cnt_d = cyc_cnt_q + CNT_ONE;
          if (bus.inst_ready) begin
            inst_cnt_d = inst_cnt_q + CNT_ONE;
            if (halt_req) begin
              state_d = HALTED;
            end else begin
              pc_d    = next_pc;
              state_d = FETCH;
            end
          end
`ifdef STALL_COUNT_EN
          else begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
          end
`endif
        end
        IDLE:    state_d = IDLE;
        HALTED:  state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      pc_q       <= START_PC;
      inst_out_q <= '0;
      inst_pc_q  <= '0;
      inst_cnt_q <= '0;
      cyc_cnt_q  <= '0;
`ifdef STALL_COUNT_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_out_q <= inst_out_d;
      inst_pc_q  <= inst_pc_d;
      inst_cnt_q <= inst_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
`ifdef STALL_COUNT_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  assign bus.imem_req   = (state_q == FETCH);
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = (state_q == ISSUE);
  assign bus.inst_out   = inst_out_q;
  assign bus.inst_pc    = inst_pc_q;
  assign PC             = pc_q;
  assign halted         = (state_q == HALTED);
  assign InstCounter    = inst_cnt_q;
  assign CycleCounter   = cyc_cnt_q;
`ifdef STALL_COUNT_EN
  assign StallCounter   = stall_cnt_q;
`endif

endmodule
